// File: rtl/tdc_frame_reader.sv
// Frame consumer for the TDC data channel: buffers one frame from the RAM write port,
// streams it on valid/ready, then acknowledges through the FPGA/PC four-phase handshake.
module tdc_frame_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              SYSCLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] ram_data,
   input  logic [ADDR_W-1:0] ram_address,
   input  logic              ram_we,
   input  logic              handshake_fpga,
   output logic              handshake_pc,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [CNT_W-1:0]  frame_count,
   output logic              write_err
);

   typedef enum logic [1:0] {
      S_CAPTURE = 2'd0,
      S_READ    = 2'd1,
      S_ACK     = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic r_rst_meta;
   logic r_rst_sync;
   logic w_rst;

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_ram_q;

   logic [ADDR_W-1:0] r_max_addr;
   logic              r_has_data;
   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_more;
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_out_last;
   logic [CNT_W-1:0]  r_frame_count;
   logic              r_write_err;

   logic w_wr_en;
   logic w_out_adv;
   logic w_s1_adv;
   logic w_rd_en;
   logic w_rd_at_max;
   logic w_last_xfer;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge SYSCLK or posedge RESET) begin
      if (RESET) begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= 1'b1;
      end else begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst = r_rst_sync;

   assign w_wr_en     = ram_we && (r_state == S_CAPTURE) && !w_rst;
   assign w_out_adv   = !r_out_valid || out_ready;
   assign w_s1_adv    = !r_s1_valid || w_out_adv;
   assign w_rd_en     = (r_state == S_READ) && r_rd_more && w_s1_adv;
   assign w_rd_at_max = (r_rd_addr == r_max_addr);
   assign w_last_xfer = r_out_valid && out_ready && r_out_last;

   always_ff @(posedge SYSCLK) begin
      if (w_wr_en) begin
         r_mem[ram_address] <= ram_data;
      end
   end

   always_ff @(posedge SYSCLK) begin
      if (w_rd_en) begin
         r_ram_q <= r_mem[r_rd_addr];
      end
   end

   always_ff @(posedge SYSCLK or posedge w_rst) begin
      if (w_rst) begin
         r_state <= S_CAPTURE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_CAPTURE: begin
            if (handshake_fpga) begin
               w_state_next = (r_has_data || w_wr_en) ? S_READ : S_ACK;
            end
         end
         S_READ: begin
            if (w_last_xfer) begin
               w_state_next = S_ACK;
            end
         end
         S_ACK: begin
            if (!handshake_fpga) begin
               w_state_next = S_RELEASE;
            end
         end
         S_RELEASE: w_state_next = S_CAPTURE;
         default:   w_state_next = S_CAPTURE;
      endcase
   end

   always_ff @(posedge SYSCLK or posedge w_rst) begin
      if (w_rst) begin
         r_max_addr    <= '0;
         r_has_data    <= 1'b0;
         r_rd_addr     <= '0;
         r_rd_more     <= 1'b1;
         r_s1_valid    <= 1'b0;
         r_s1_last     <= 1'b0;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_last    <= 1'b0;
         r_frame_count <= '0;
         r_write_err   <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_has_data <= 1'b1;
            if (ram_address > r_max_addr) begin
               r_max_addr <= ram_address;
            end
         end
         if (r_state == S_RELEASE) begin
            r_max_addr <= '0;
            r_has_data <= 1'b0;
         end
         if (ram_we && (r_state != S_CAPTURE)) begin
            r_write_err <= 1'b1;
         end
         if ((w_state_next == S_ACK) && (r_state != S_ACK)) begin
            r_frame_count <= r_frame_count + 1'b1;
         end

         // Two-stage pipeline: RAM output register feeds the output register; both
         // advance whenever the stage ahead is empty or draining, so ready=1 gives no bubbles.
         if (r_state != S_READ) begin
            r_rd_addr   <= '0;
            r_rd_more   <= 1'b1;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end else begin
            if (w_rd_en) begin
               r_rd_addr  <= r_rd_addr + 1'b1;
               r_s1_valid <= 1'b1;
               r_s1_last  <= w_rd_at_max;
               if (w_rd_at_max) begin
                  r_rd_more <= 1'b0;
               end
            end else if (w_s1_adv) begin
               r_s1_valid <= 1'b0;
            end
            if (w_out_adv) begin
               r_out_valid <= r_s1_valid;
               r_out_last  <= r_s1_valid && r_s1_last;
               if (r_s1_valid) begin
                  r_out_data <= r_ram_q;
               end
            end
         end
      end
   end

   assign handshake_pc = (r_state == S_ACK);
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign out_last     = r_out_last;
   assign frame_count  = r_frame_count;
   assign write_err    = r_write_err;

endmodule

// File: doc/tdc_frame_reader.md
Name: tdc_frame_reader

Overview:
- Downstream consumer of the TDC data channel's frame-write port (RAM data/address/write-enable plus the FPGA/PC four-phase handshake).
- Captures each frame into an internal 2^ADDR_W x DATA_W buffer and streams it out on a valid/ready interface toward the IPbus/readout side.
- Acts as the "PC" end of the handshake, so the channel can run unattended at SYSCLK (192 MHz).

Parameters:
- ADDR_W, 8, frame buffer address width (depth 2^ADDR_W words)
- DATA_W, 32, word width
- CNT_W, 16, width of frame counter

Ports:
- SYSCLK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- ram_data  in  DATA_W  write data from data channel
- ram_address  in  ADDR_W  write address from data channel
- ram_we  in  1  write strobe, one word per cycle high
- handshake_fpga  in  1  high = frame complete (channel side)
- handshake_pc  out  1  high = frame consumed (acknowledge)
- out_data  out  DATA_W  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word when out_valid & out_ready
- out_last  out  1  qualifies final word of frame
- frame_count  out  CNT_W  frames acknowledged since reset, wraps
- write_err  out  1  sticky: write arrived outside CAPTURE

Behaviour:
- Reset (async assert, sync release) drives all outputs to 0, state=CAPTURE, max_addr cleared, has_data=0. Buffer contents are not reset.
- CAPTURE:
  - ram_we=1 writes ram_data to buf[ram_address] and sets has_data.
  - Tracks max_addr = max of addresses written.
  - Word count N = max_addr+1 (ADDR_W+1 bits; 256 words is legal).
  - handshake_fpga sampled high -> READ if has_data, else ACK (empty frame, no words emitted).
  - A write in the same cycle handshake_fpga is first sampled high is accepted and counted.
- READ:
  - Synchronous buffer read, one-cycle latency; addresses 0..max_addr in order.
  - First out_valid is asserted exactly 2 cycles after the CAPTURE->READ transition edge.
  - out_data, out_valid and out_last are registered and held stable while out_valid & !out_ready.
  - The next word is fetched so that with out_ready held 1 the stream has no bubbles: one word per cycle.
  - out_last=1 only with the word at max_addr.
  - The transfer with out_last -> ACK.
- ACK:
  - handshake_pc=1; frame_count increments by 1 on entry (wraps at 2^CNT_W).
  - Waits for handshake_fpga=0, then -> RELEASE.
- RELEASE:
  - handshake_pc=0, max_addr and has_data cleared; -> CAPTURE next cycle.
- Writes (ram_we=1) in READ/ACK/RELEASE are discarded (buffer untouched) and set write_err, which clears only on RESET.
- out_valid=0 in all states except READ.
- out_ready may toggle arbitrarily; no word is duplicated or dropped.
- RESET mid-READ aborts the frame: no out_last, handshake_pc=0, frame_count=0.

Test Plan:
- Write addrs 0..3 = 0xA0..0xA3, raise handshake_fpga, out_ready=1 -> out_valid 2 cycles after transition; 0xA0..0xA3 on consecutive cycles; out_last on 0xA3; handshake_pc=1; frame_count=1.
- Same frame with out_ready toggling 1,0,0,1,... -> four words in order, each held stable while stalled; no duplicates.
- Full frame: writes to addrs 0..255 -> 256 words streamed; out_last only on addr 255; N wrap-safe.
- Empty frame: handshake_fpga high with no writes -> no out_valid; handshake_pc rises; drop handshake_fpga -> handshake_pc falls one cycle later; frame_count increments.
- ram_we pulse during READ -> write_err=1 sticky; streamed data unchanged; the next frame still reads correctly.
- RESET asserted mid-READ (after word 1 of 4) -> all outputs 0 immediately; after release, a new 2-word frame streams correctly with frame_count=1 at its ACK.
